// File: rtl/ex_mem_reg.sv
// ============================================================================
// ex_mem_reg
// ----------------------------------------------------------------------------
// EX/MEM pipeline register of the 5-stage MIPS core.
//
// The register captures the EX-stage results and control each cycle and
// presents them to the MEM stage, the MEM-stage forwarding unit and the
// hazard logic. It also formats stores for the data memory:
//   - o_mem_byte_en : little-endian byte enables (0000 unless a store)
//   - o_mem_wdata   : store data replicated across the byte lanes
// Store data is replaced by the MEM/WB load value whenever the MEM-stage
// forwarding unit requests it (i_MEM_forward). That override only affects
// o_mem_wdata and never touches the registered state.
//
// Update priority on every rising edge: reset > flush > stall > load.
//
// Optional build macro:
//   MEM_MISALIGN_TRAP_EN - when defined, misaligned memory accesses are
//                          flagged on o_EX_MEM_misalign and captured with
//                          mem_read/mem_write/reg_write cleared. When not
//                          defined, o_EX_MEM_misalign is tied low and the
//                          low address bits are ignored where they do not
//                          select a lane.
//
// Ports
//   clk                      in   core clock, rising edge
//   reset                    in   synchronous, active-high
//   i_stall                  in   hold current contents
//   i_flush                  in   load a bubble
//   i_EX_valid               in   EX holds a real instruction
//   i_EX_alu_result   [31:0] in   ALU result / memory address
//   i_EX_store_data   [31:0] in   Rt value after EX forwarding
//   i_EX_Rt            [4:0] in   Rt index
//   i_EX_write_reg     [4:0] in   destination register
//   i_EX_mem_read/_mem_write/_reg_write/_mem_to_reg  in  control
//   i_EX_mem_size      [1:0] in   00 byte, 01 half, 1x word
//   i_EX_load_unsigned       in   zero-extend load
//   i_MEM_forward            in   use i_MEM_WB_rdata as store data
//   i_MEM_WB_rdata    [31:0] in   load data held in MEM/WB
//   o_EX_MEM_*               out  registered copies of the EX fields
//   o_EX_MEM_misalign        out  registered misalignment flag
//   o_mem_wdata       [31:0] out  lane-replicated store data (comb.)
//   o_mem_byte_en      [3:0] out  byte enables (comb.)
// ============================================================================
module ex_mem_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_EX_valid,
    input  logic [31:0] i_EX_alu_result,
    input  logic [31:0] i_EX_store_data,
    input  logic [4:0]  i_EX_Rt,
    input  logic [4:0]  i_EX_write_reg,
    input  logic        i_EX_mem_read,
    input  logic        i_EX_mem_write,
    input  logic        i_EX_reg_write,
    input  logic        i_EX_mem_to_reg,
    input  logic [1:0]  i_EX_mem_size,
    input  logic        i_EX_load_unsigned,
    input  logic        i_MEM_forward,
    input  logic [31:0] i_MEM_WB_rdata,
    output logic        o_EX_MEM_valid,
    output logic [31:0] o_EX_MEM_alu_result,
    output logic [4:0]  o_EX_MEM_Rt,
    output logic [4:0]  o_EX_MEM_write_reg,
    output logic        o_EX_MEM_mem_read,
    output logic        o_EX_MEM_mem_write,
    output logic        o_EX_MEM_reg_write,
    output logic        o_EX_MEM_mem_to_reg,
    output logic [1:0]  o_EX_MEM_mem_size,
    output logic        o_EX_MEM_load_unsigned,
    output logic        o_EX_MEM_misalign,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_byte_en
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Store data travels with the instruction but is only visible through
    // the formatted o_mem_wdata bus.
    logic [31:0] store_data_reg;

    // ------------------------------------------------------------------------
    // Capture-side misalignment handling
    // ------------------------------------------------------------------------
    logic misalign_next;   // flag value to be captured
    logic kill_mem_next;   // clear mem_read/mem_write/reg_write at capture

`ifdef MEM_MISALIGN_TRAP_EN
    logic addr_misaligned;

    always_comb begin
        addr_misaligned = 1'b0;
        unique case (i_EX_mem_size)
            SIZE_BYTE: addr_misaligned = 1'b0;
            SIZE_HALF: addr_misaligned = i_EX_alu_result[0];
            default:   addr_misaligned = |i_EX_alu_result[1:0];
        endcase
    end

    // Only a real memory access can be misaligned; ALU instructions carry
    // arbitrary alu_result / mem_size values that must not raise a trap.
    assign misalign_next = addr_misaligned & i_EX_valid
                         & (i_EX_mem_read | i_EX_mem_write);
    assign kill_mem_next = misalign_next;
`else
    assign misalign_next = 1'b0;
    assign kill_mem_next = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            o_EX_MEM_valid         <= 1'b0;
            o_EX_MEM_alu_result    <= 32'd0;
            store_data_reg         <= 32'd0;
            o_EX_MEM_Rt            <= 5'd0;
            o_EX_MEM_write_reg     <= 5'd0;
            o_EX_MEM_mem_read      <= 1'b0;
            o_EX_MEM_mem_write     <= 1'b0;
            o_EX_MEM_reg_write     <= 1'b0;
            o_EX_MEM_mem_to_reg    <= 1'b0;
            o_EX_MEM_mem_size      <= 2'b00;
            o_EX_MEM_load_unsigned <= 1'b0;
            o_EX_MEM_misalign      <= 1'b0;
        end else if (!i_stall) begin
            o_EX_MEM_valid         <= i_EX_valid;
            o_EX_MEM_alu_result    <= i_EX_alu_result;
            store_data_reg         <= i_EX_store_data;
            o_EX_MEM_Rt            <= i_EX_Rt;
            o_EX_MEM_write_reg     <= i_EX_write_reg;
            // An invalid EX slot lands as a bubble.
            o_EX_MEM_mem_read      <= i_EX_mem_read  & i_EX_valid & ~kill_mem_next;
            o_EX_MEM_mem_write     <= i_EX_mem_write & i_EX_valid & ~kill_mem_next;
            o_EX_MEM_reg_write     <= i_EX_reg_write & i_EX_valid & ~kill_mem_next;
            o_EX_MEM_mem_to_reg    <= i_EX_mem_to_reg & i_EX_valid;
            o_EX_MEM_mem_size      <= i_EX_mem_size;
            o_EX_MEM_load_unsigned <= i_EX_load_unsigned;
            o_EX_MEM_misalign      <= misalign_next;
        end
    end

    // ------------------------------------------------------------------------
    // Store formatting (combinational from registered state)
    // ------------------------------------------------------------------------
    logic [31:0] mem_data;

    // Late forwarding of a load result into a store in the following slot.
    assign mem_data = i_MEM_forward ? i_MEM_WB_rdata : store_data_reg;

    // Each byte lane picks the byte it would carry for each access size:
    // byte stores put D[7:0] on every lane, half stores alternate the two
    // low bytes, word stores pass D straight through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                o_mem_wdata[gi*8 +: 8] = mem_data[gi*8 +: 8];
                unique case (o_EX_MEM_mem_size)
                    SIZE_BYTE: o_mem_wdata[gi*8 +: 8] = mem_data[7:0];
                    SIZE_HALF: o_mem_wdata[gi*8 +: 8] = mem_data[(gi % 2)*8 +: 8];
                    default:   o_mem_wdata[gi*8 +: 8] = mem_data[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    always_comb begin
        o_mem_byte_en = 4'b0000;
        if (o_EX_MEM_mem_write) begin
            unique case (o_EX_MEM_mem_size)
                SIZE_BYTE: o_mem_byte_en = 4'b0001 << o_EX_MEM_alu_result[1:0];
                SIZE_HALF: o_mem_byte_en = o_EX_MEM_alu_result[1] ? 4'b1100 : 4'b0011;
                default:   o_mem_byte_en = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed cases followed by random traffic.
// A reference model predicts the full output set for every clock edge and
// queues it; an independent monitor pops one entry per cycle and compares.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset, i_stall, i_flush, i_EX_valid;
    logic [31:0] i_EX_alu_result, i_EX_store_data, i_MEM_WB_rdata;
    logic [4:0]  i_EX_Rt, i_EX_write_reg;
    logic        i_EX_mem_read, i_EX_mem_write, i_EX_reg_write, i_EX_mem_to_reg;
    logic [1:0]  i_EX_mem_size;
    logic        i_EX_load_unsigned, i_MEM_forward;
    logic        o_EX_MEM_valid;
    logic [31:0] o_EX_MEM_alu_result;
    logic [4:0]  o_EX_MEM_Rt, o_EX_MEM_write_reg;
    logic        o_EX_MEM_mem_read, o_EX_MEM_mem_write, o_EX_MEM_reg_write, o_EX_MEM_mem_to_reg;
    logic [1:0]  o_EX_MEM_mem_size;
    logic        o_EX_MEM_load_unsigned, o_EX_MEM_misalign;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_byte_en;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .reset(reset), .i_stall(i_stall), .i_flush(i_flush),
        .i_EX_valid(i_EX_valid), .i_EX_alu_result(i_EX_alu_result),
        .i_EX_store_data(i_EX_store_data), .i_EX_Rt(i_EX_Rt),
        .i_EX_write_reg(i_EX_write_reg), .i_EX_mem_read(i_EX_mem_read),
        .i_EX_mem_write(i_EX_mem_write), .i_EX_reg_write(i_EX_reg_write),
        .i_EX_mem_to_reg(i_EX_mem_to_reg), .i_EX_mem_size(i_EX_mem_size),
        .i_EX_load_unsigned(i_EX_load_unsigned), .i_MEM_forward(i_MEM_forward),
        .i_MEM_WB_rdata(i_MEM_WB_rdata),
        .o_EX_MEM_valid(o_EX_MEM_valid), .o_EX_MEM_alu_result(o_EX_MEM_alu_result),
        .o_EX_MEM_Rt(o_EX_MEM_Rt), .o_EX_MEM_write_reg(o_EX_MEM_write_reg),
        .o_EX_MEM_mem_read(o_EX_MEM_mem_read), .o_EX_MEM_mem_write(o_EX_MEM_mem_write),
        .o_EX_MEM_reg_write(o_EX_MEM_reg_write), .o_EX_MEM_mem_to_reg(o_EX_MEM_mem_to_reg),
        .o_EX_MEM_mem_size(o_EX_MEM_mem_size), .o_EX_MEM_load_unsigned(o_EX_MEM_load_unsigned),
        .o_EX_MEM_misalign(o_EX_MEM_misalign), .o_mem_wdata(o_mem_wdata),
        .o_mem_byte_en(o_mem_byte_en)
    );

    typedef struct {
        logic        rst, flush, stall, valid;
        logic [31:0] alu, sd;
        logic [4:0]  rt, wr;
        logic        mr, mw, rw, m2r;
        logic [1:0]  size;
        logic        lu, fwd;
        logic [31:0] rdata;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] alu, sd;
        logic [4:0]  rt, wr;
        logic        mr, mw, rw, m2r;
        logic [1:0]  size;
        logic        lu, mis;
    } state_t;

    typedef struct {
        state_t      st;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          txn;
    } exp_t;

    exp_t   exp_q[$];
    state_t model;
    int     tests = 0;
    int     failed = 0;
    int     txn_count = 0;

    function automatic state_t zero_state();
        state_t z;
        z.valid = 0; z.alu = 0; z.sd = 0; z.rt = 0; z.wr = 0;
        z.mr = 0; z.mw = 0; z.rw = 0; z.m2r = 0; z.size = 0; z.lu = 0; z.mis = 0;
        return z;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.flush = 0; s.stall = 0; s.valid = 0; s.alu = 0; s.sd = 0;
        s.rt = 0; s.wr = 0; s.mr = 0; s.mw = 0; s.rw = 0; s.m2r = 0;
        s.size = 0; s.lu = 0; s.fwd = 0; s.rdata = 0;
        return s;
    endfunction

    // Access width in bytes (size 11 behaves as a word).
    function automatic int nbytes(logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the prediction.
    task automatic apply(input stim_t s);
        exp_t e;
        int   n, base, off;
        logic [31:0] d;
        logic trap;
        @(negedge clk);
        reset = s.rst; i_flush = s.flush; i_stall = s.stall; i_EX_valid = s.valid;
        i_EX_alu_result = s.alu; i_EX_store_data = s.sd; i_EX_Rt = s.rt;
        i_EX_write_reg = s.wr; i_EX_mem_read = s.mr; i_EX_mem_write = s.mw;
        i_EX_reg_write = s.rw; i_EX_mem_to_reg = s.m2r; i_EX_mem_size = s.size;
        i_EX_load_unsigned = s.lu; i_MEM_forward = s.fwd; i_MEM_WB_rdata = s.rdata;

        if (s.rst || s.flush) begin
            model = zero_state();
        end else if (!s.stall) begin
            n    = nbytes(s.size);
            trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            trap = s.valid && (s.mr || s.mw) && ((s.alu % n) != 0);
`endif
            model.valid = s.valid;
            model.alu   = s.alu;
            model.sd    = s.sd;
            model.rt    = s.rt;
            model.wr    = s.wr;
            model.mr    = s.mr && s.valid && !trap;
            model.mw    = s.mw && s.valid && !trap;
            model.rw    = s.rw && s.valid && !trap;
            model.m2r   = s.m2r && s.valid;
            model.size  = s.size;
            model.lu    = s.lu;
            model.mis   = trap;
        end

        e.st  = model;
        e.txn = txn_count++;
        d = s.fwd ? s.rdata : model.sd;
        n = nbytes(model.size);
        // Replicate the low n bytes of D across the word.
        e.wdata = (n == 1) ? 32'(d[7:0]) * 32'h0101_0101 :
                  (n == 2) ? 32'(d[15:0]) * 32'h0001_0001 : d;
        // Enabled lanes are the n bytes starting at the address rounded
        // down to the access width.
        e.be = 4'b0000;
        if (model.mw) begin
            base = (int'(model.alu[1:0]) / n) * n;
            for (int l = 0; l < 4; l++) begin
                off = l - base;
                if (off >= 0 && off < n) e.be[l] = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int txn, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL txn %0d %s: got %h, expected %h", txn, name, act, req);
        end
    endtask

    // Monitor: the register presents a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid",     e.txn, 32'(o_EX_MEM_valid),         32'(e.st.valid));
                chk("alu",       e.txn, o_EX_MEM_alu_result,         e.st.alu);
                chk("rt",        e.txn, 32'(o_EX_MEM_Rt),            32'(e.st.rt));
                chk("write_reg", e.txn, 32'(o_EX_MEM_write_reg),     32'(e.st.wr));
                chk("ctrl",      e.txn, {28'd0, o_EX_MEM_mem_read, o_EX_MEM_mem_write,
                                         o_EX_MEM_reg_write, o_EX_MEM_mem_to_reg},
                                        {28'd0, e.st.mr, e.st.mw, e.st.rw, e.st.m2r});
                chk("size_lu",   e.txn, {29'd0, o_EX_MEM_mem_size, o_EX_MEM_load_unsigned},
                                        {29'd0, e.st.size, e.st.lu});
                chk("misalign",  e.txn, 32'(o_EX_MEM_misalign),      32'(e.st.mis));
                chk("wdata",     e.txn, o_mem_wdata,                 e.wdata);
                chk("byte_en",   e.txn, 32'(o_mem_byte_en),          32'(e.be));
                $display("[TB] txn %0d valid=%0b addr=%h mw=%0b be=%b wdata=%h",
                         e.txn, o_EX_MEM_valid, o_EX_MEM_alu_result,
                         o_EX_MEM_mem_write, o_mem_byte_en, o_mem_wdata);
            end
        end
    end

    function automatic stim_t store(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [1:0] size);
        stim_t s;
        s = idle();
        s.valid = 1; s.alu = addr; s.sd = data; s.mw = 1; s.size = size;
        s.rt = 5'd9;
        return s;
    endfunction

    initial begin
        stim_t s;
        model = zero_state();

        // Reset for two cycles.
        s = idle(); s.rst = 1;
        apply(s); apply(s);

        // Aligned word, byte and half stores.
        apply(store(32'h1000_0004, 32'hDEAD_BEEF, 2'b10));
        apply(store(32'h1000_0003, 32'h0000_00A5, 2'b00));
        apply(store(32'h1000_0002, 32'h0000_1234, 2'b01));

        // Stall for 3 cycles while EX inputs keep changing.
        for (int i = 0; i < 3; i++) begin
            s = store(32'h2000_0000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 2'b10);
            s.stall = 1;
            apply(s);
        end
        apply(store(32'h3000_0008, 32'h0BAD_F00D, 2'b10));

        // Flush and stall together load a bubble.
        s = store(32'h4000_0000, 32'h5555_5555, 2'b10);
        s.stall = 1; s.flush = 1;
        apply(s);

        // Late forwarding on a registered word store, then released.
        apply(store(32'h1000_0010, 32'h7777_8888, 2'b10));
        s = idle(); s.stall = 1; s.fwd = 1; s.rdata = 32'hCAFE_0001;
        apply(s);
        s.fwd = 0;
        apply(s);

        // Invalid EX slot with mem_write set lands as a bubble.
        s = store(32'h1000_0020, 32'h1234_5678, 2'b10);
        s.valid = 0; s.rw = 1; s.mr = 1;
        apply(s);

        // Misaligned word store and misaligned half load.
        apply(store(32'h1000_0002, 32'hA1B2_C3D4, 2'b10));
        s = store(32'h1000_0005, 32'hA1B2_C3D4, 2'b01);
        s.mw = 0; s.mr = 1; s.rw = 1; s.m2r = 1;
        apply(s);
        apply(store(32'h1000_0003, 32'hA1B2_C3D4, 2'b11));

        // Reset arriving during a stall.
        s = store(32'h5000_0000, 32'h0F0F_0F0F, 2'b10);
        apply(s);
        s.stall = 1; s.rst = 1;
        apply(s);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            s.rst   = ($urandom_range(0, 31) == 0);
            s.flush = ($urandom_range(0, 7) == 0);
            s.stall = ($urandom_range(0, 3) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.alu   = $urandom;
            s.sd    = $urandom;
            s.rt    = 5'($urandom);
            s.wr    = 5'($urandom);
            s.mr    = 1'($urandom);
            s.mw    = 1'($urandom);
            s.rw    = 1'($urandom);
            s.m2r   = 1'($urandom);
            s.size  = 2'($urandom);
            s.lu    = 1'($urandom);
            s.fwd   = ($urandom_range(0, 2) == 0);
            s.rdata = $urandom;
            apply(s);
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
